serial2tcp_tx_arbiter: RTL and testbench
========================================

// Module: serial2tcp_tx_arbiter
// PURPOSE
//  Shares the single serial2tcp sink byte stream between NUM_REQ requester streams.
//  Round-robin, burst-granular arbitration: a grant is held until the requester's last byte or MAX_BURST bytes.
//  Sits between on-chip byte producers (UART bridges, debug taps, counters) and serial2tcp_loopback/serial2tcp sink.
// PARAMETERS
//  NUM_REQ    4   number of requester streams (2..8)
//  MAX_BURST  16  max bytes per grant before forced rotation (1..255)
// PORTS
//  sys_clk      in   1          system clock; all logic on rising edge
//  sys_rst_n    in   1          asynchronous, active-low reset
//  req_valid    in   NUM_REQ    per-requester byte valid
//  req_ready    out  NUM_REQ    per-requester byte accepted (only granted bit may be 1)
//  req_data     in   8*NUM_REQ  requester i byte on [8*i+7:8*i]
//  req_last     in   NUM_REQ    qualifies req_data as final byte of requester burst
//  sink_valid   out  1          byte valid toward serial2tcp sink
//  sink_ready   in   1          sink accepts byte when sink_valid & sink_ready
//  sink_data    out  8          byte toward sink
//  grant_id     out  clog2(NUM_REQ)  index of current/last granted requester
//  busy         out  1          1 while a grant is active (any state other than IDLE)
// BEHAVIOUR
//  Reset (sys_rst_n low, async): state=IDLE, sink_valid=0, sink_data=0, req_ready=0, grant_id=0, busy=0, rr pointer=0, burst count=0.
//  Transfer = valid&ready on same edge; one byte per cycle max; no bytes dropped, duplicated or reordered.
//  FSM states: IDLE, TAG (macro only), PASS.
//  IDLE: sink_valid=0, req_ready=0. If any req_valid: pick first set bit searching from (rr_ptr) upward, wrapping;
//    register grant_id, clear count, go TAG (macro) or PASS. Grant visible 1 cycle after req_valid sampled.
//  PASS: combinational forward: sink_valid=req_valid[g], sink_data=req_data[g], req_ready[g]=sink_ready, others 0.
//    On each transfer count+=1 (width clog2(MAX_BURST+1), never wraps: end condition fires first).
//    End of grant on transfer with req_last[g]=1 OR count reaches MAX_BURST: rr_ptr=(g+1) mod NUM_REQ, go IDLE.
//    req_valid[g] low mid-burst: grant held, sink_valid=0, no timeout.
//  Simultaneous last and MAX_BURST on same transfer: single end, rr_ptr advances once.
//  Requests arriving on other channels during PASS wait; no preemption.
//  IDLE->grant is registered, so back-to-back bursts have 1 idle cycle between them (sink_valid=0).
//  busy=1 in TAG/PASS, 0 in IDLE. grant_id holds last value in IDLE.
//  Reset asserted mid-burst: immediate return to reset values; requester must resend burst.
// CONFIGURATION
//  SERIAL2TCP_ARB_TAG_EN defined: after grant, TAG state drives sink_valid=1, sink_data=TAG_BASE|grant_id
//    (TAG_BASE=8'hC0), req_ready=0, held until sink_ready; then PASS. Tag not counted in MAX_BURST.
//  Not defined: TAG state absent; IDLE goes straight to PASS; stream is raw bytes.
// STRUCTURE
//  serial2tcp_pkg: state encoding (IDLE/TAG/PASS), TAG_BASE constant, clog2 helper.
//  Sub-module serial2tcp_rr_pick: combinational round-robin picker (req vector, rr_ptr -> found, index).
//  Top holds FSM, count, rr_ptr, grant register and output mux.
// TESTING
//  Single req0 burst 3 bytes 8'h10,11,12, last on 12, sink_ready=1 -> sink sees 10,11,12; busy drops next cycle; rr_ptr=1.
//  All reqs valid continuously, last every byte -> grant order 0,1,2,3,0..., one idle cycle between bytes.
//  req2 streams with no last, MAX_BURST=16 -> exactly 16 bytes then grant moves to req3 if valid, else back to req2.
//  sink_ready toggled 1/0 each cycle during burst -> req_ready[g] mirrors sink_ready; no byte lost or repeated; sink_data stable while stalled.
//  sys_rst_n pulsed low mid-burst -> sink_valid, req_ready, busy, grant_id all 0 immediately; next grant starts at req0.
//  With SERIAL2TCP_ARB_TAG_EN, req1 one byte 8'h55 last -> sink sees 8'hC1 then 8'h55; tag held while sink_ready=0.

Source files
------------

// File: rtl/serial2tcp_pkg.sv
// Shared types and constants for the serial2tcp transmit arbiter.
// The FSM encoding and tag constant are also used when SERIAL2TCP_ARB_TAG_EN is set.
package serial2tcp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_PASS = 2'd2
  } arb_state_e;

  localparam logic [7:0] TAG_BASE = 8'hC0;

  // Index width, never below one bit
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial2tcp_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around to index 0.
module serial2tcp_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx   = W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/serial2tcp_tx_arbiter.sv
// Burst-granular round-robin arbiter sharing one serial2tcp sink stream.
// Define SERIAL2TCP_ARB_TAG_EN to prefix each grant with a TAG_BASE|id byte.
module serial2tcp_tx_arbiter
  import serial2tcp_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  localparam int GW = clog2(NUM_REQ),
  localparam int CW = clog2(MAX_BURST + 1)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic                 sink_valid,
  input  logic                 sink_ready,
  output logic [7:0]           sink_data,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [GW-1:0] gnt_nxt;
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          xfer;

  serial2tcp_rr_pick #(
    .N (NUM_REQ),
    .W (GW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cnt_inc = cnt_q + CW'(1);
  assign gnt_nxt = (gnt_q == GW'(NUM_REQ - 1)) ? '0 : gnt_q + GW'(1);
  assign xfer    = req_valid[gnt_q] & sink_ready;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    sink_valid = 1'b0;
    sink_data  = 8'h00;
    req_ready  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d = pick_idx;
          cnt_d = '0;
`ifdef SERIAL2TCP_ARB_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_PASS;
`endif
        end
      end
`ifdef SERIAL2TCP_ARB_TAG_EN
      ST_TAG: begin
        sink_valid = 1'b1;
        sink_data  = TAG_BASE | 8'(gnt_q);
        if (sink_ready) state_d = ST_PASS;
      end
`endif
      ST_PASS: begin
        sink_valid       = req_valid[gnt_q];
        sink_data        = req_data[8*gnt_q +: 8];
        req_ready[gnt_q] = sink_ready;
        if (xfer) begin
          cnt_d = cnt_inc;
          // last and MAX_BURST together still end the grant only once
          if (req_last[gnt_q] || cnt_inc == CW'(MAX_BURST)) begin
            rr_d    = gnt_nxt;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id = gnt_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial2tcp_tx_arbiter.sv
// Directed self-checking bench for serial2tcp_tx_arbiter (NUM_REQ=4, MAX_BURST=16).
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
module tb_serial2tcp_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        sink_valid;
  logic        sink_ready;
  logic [7:0]  sink_data;
  logic [1:0]  grant_id;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  serial2tcp_tx_arbiter #(
    .NUM_REQ   (4),
    .MAX_BURST (16)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_last   (req_last),
    .sink_valid (sink_valid),
    .sink_ready (sink_ready),
    .sink_data  (sink_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int ch, input logic [7:0] b);
    req_data[8*ch +: 8] = b;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    sink_ready = 1'b1;
    #1;
    chk("rst_sink_valid", 32'(sink_valid), 0);
    chk("rst_sink_data", 32'(sink_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifndef SERIAL2TCP_ARB_TAG_EN
    // single 3-byte burst on req0
    req_valid = 4'b0001;
    set_byte(0, 8'h10);
    #1;
    chk("a_idle_valid", 32'(sink_valid), 0);
    chk("a_idle_busy", 32'(busy), 0);
    tick();
    chk("a_gnt", 32'(grant_id), 0);
    chk("a_busy", 32'(busy), 1);
    chk("a_b0", 32'(sink_data), 32'h10);
    chk("a_rdy", 32'(req_ready), 32'b0001);
    tick();
    set_byte(0, 8'h11);
    #1;
    chk("a_b1", 32'(sink_data), 32'h11);
    tick();
    set_byte(0, 8'h12);
    req_last = 4'b0001;
    #1;
    chk("a_b2", 32'(sink_data), 32'h12);
    chk("a_b2_valid", 32'(sink_valid), 1);
    tick();

    // all requesters, one-byte bursts; rr pointer now 1
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < 4; i++) set_byte(i, 8'hA0 + 8'(i));
    #1;
    chk("a_end_busy", 32'(busy), 0);
    chk("a_end_valid", 32'(sink_valid), 0);
    for (int k = 0; k < 5; k++) begin
      int g;
      g = (k + 1) % 4;
      tick();
      chk($sformatf("rr%0d_gnt", k), 32'(grant_id), 32'(g));
      chk($sformatf("rr%0d_data", k), 32'(sink_data), 32'hA0 + 32'(g));
      chk($sformatf("rr%0d_rdy", k), 32'(req_ready), 32'(1 << g));
      tick();
      chk($sformatf("rr%0d_gap", k), 32'(sink_valid), 0);
    end
    // rr pointer now 2

    // req2 streams without last; req3 waiting
    req_valid = 4'b1100;
    req_last  = 4'b1000;
    set_byte(3, 8'h3F);
    tick();
    for (int k = 0; k < 16; k++) begin
      set_byte(2, 8'h20 + 8'(k));
      #1;
      chk($sformatf("mb%0d_gnt", k), 32'(grant_id), 2);
      chk($sformatf("mb%0d_data", k), 32'(sink_data), 32'h20 + 32'(k));
      chk($sformatf("mb%0d_valid", k), 32'(sink_valid), 1);
      tick();
    end
    chk("mb_end_busy", 32'(busy), 0);
    tick();
    chk("mb_next_gnt", 32'(grant_id), 3);
    chk("mb_next_data", 32'(sink_data), 32'h3F);
    tick();
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    tick();
    chk("mb_back_gnt", 32'(grant_id), 2);
    chk("mb_back_busy", 32'(busy), 1);

    // stall pattern: sink_ready alternates
    sink_ready = 1'b0;
    set_byte(2, 8'h30);
    #1;
    chk("st0_rdy", 32'(req_ready), 0);
    chk("st0_data", 32'(sink_data), 32'h30);
    tick();
    sink_ready = 1'b1;
    #1;
    chk("st1_data", 32'(sink_data), 32'h30);
    chk("st1_rdy", 32'(req_ready), 32'b0100);
    tick();
    sink_ready = 1'b0;
    set_byte(2, 8'h31);
    #1;
    chk("st2_data", 32'(sink_data), 32'h31);
    chk("st2_rdy", 32'(req_ready), 0);
    tick();
    sink_ready = 1'b1;
    #1;
    chk("st3_rdy", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("hold_valid", 32'(sink_valid), 0);
    chk("hold_busy", 32'(busy), 1);
    tick();
    chk("hold_gnt", 32'(grant_id), 2);
    req_valid = 4'b0100;

    // reset mid-burst
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(sink_valid), 0);
    chk("mr_rdy", 32'(req_ready), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_gnt", 32'(grant_id), 0);
    #2 rst_n = 1'b1;
    req_valid = 4'hF;
    tick();
    chk("mr_next_gnt", 32'(grant_id), 0);
    chk("mr_next_busy", 32'(busy), 1);
`else
    // tagged grant on req1
    req_valid  = 4'b0010;
    req_last   = 4'b0010;
    set_byte(1, 8'h55);
    sink_ready = 1'b0;
    tick();
    chk("tag_valid", 32'(sink_valid), 1);
    chk("tag_data", 32'(sink_data), 32'hC1);
    chk("tag_rdy", 32'(req_ready), 0);
    tick();
    chk("tag_hold", 32'(sink_data), 32'hC1);
    sink_ready = 1'b1;
    tick();
    chk("tag_pay", 32'(sink_data), 32'h55);
    chk("tag_pay_rdy", 32'(req_ready), 32'b0010);
    tick();
    chk("tag_end", 32'(busy), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
